// File: rtl/rrag_mem_addr_queue_if.sv
// rtl/rrag_mem_addr_queue_if.sv - RrAg-to-MEM address queue handshake bundle
interface rrag_mem_addr_queue_if #(
  parameter int PTR_W = 2
);
  logic             in_valid;
  logic [31:0]      in_addr1;
  logic [31:0]      in_addr2;
  logic [1:0]       in_opsize;
  logic             in_rep_cont;
  logic             full;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr1;
  logic [31:0]      out_addr2;
  logic [1:0]       out_opsize;
  logic             out_last;
  logic             out_xpage1;
  logic             out_xpage2;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_addr1, in_addr2, in_opsize, in_rep_cont, out_ready,
    input  full, out_valid, out_addr1, out_addr2, out_opsize, out_last,
           out_xpage1, out_xpage2, count
  );

  modport slave (
    input  in_valid, in_addr1, in_addr2, in_opsize, in_rep_cont, out_ready,
    output full, out_valid, out_addr1, out_addr2, out_opsize, out_last,
           out_xpage1, out_xpage2, count
  );
endinterface

// File: rtl/rrag_mem_addr_queue.sv
// rtl/rrag_mem_addr_queue.sv - in-order address-pair queue between RrAg and MEM with page-cross tags
module rrag_mem_addr_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 flush,
  rrag_mem_addr_queue_if.slave q
);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      addr1_mem  [DEPTH];
  logic [31:0]      addr2_mem  [DEPTH];
  logic [1:0]       opsize_mem [DEPTH];
  logic             last_mem   [DEPTH];

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W:0]   cnt;

  logic             full_w;
  logic             valid_w;
  logic             push;
  logic             pop;
  logic             kill;

  // full/valid come only from the registered count, so out_ready never reaches full
  assign full_w  = (cnt == DEPTH_CNT);
  assign valid_w = (cnt != '0);
  assign kill    = clr | flush;
  assign push    = q.in_valid & ~full_w;
  assign pop     = valid_w & q.out_ready;

  always_ff @(posedge clk) begin
    if (push && !kill) begin
      addr1_mem[wp]  <= q.in_addr1;
      addr2_mem[wp]  <= q.in_addr2;
      opsize_mem[wp] <= q.in_opsize;
      last_mem[wp]   <= ~q.in_rep_cont;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (PTR_W + 1)'(1);
        2'b01:   cnt <= cnt - (PTR_W + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  logic [1:0]  head_opsize;
  logic [31:0] head_addr1;
  logic [31:0] head_addr2;
  logic [1:0]  size_m1;
  logic [12:0] end1;
  logic [12:0] end2;

  assign head_addr1  = addr1_mem[rp];
  assign head_addr2  = addr2_mem[rp];
  assign head_opsize = opsize_mem[rp];

  // reserved size code 11 behaves as a single byte
  always_comb begin
    size_m1 = 2'd0;
    case (head_opsize)
      2'b01:   size_m1 = 2'd1;
      2'b10:   size_m1 = 2'd3;
      default: size_m1 = 2'd0;
    endcase
  end

  assign end1 = {1'b0, head_addr1[11:0]} + {11'd0, size_m1};
  assign end2 = {1'b0, head_addr2[11:0]} + {11'd0, size_m1};

  assign q.full       = full_w;
  assign q.out_valid  = valid_w;
  assign q.count      = cnt;
  assign q.out_addr1  = head_addr1;
  assign q.out_addr2  = head_addr2;
  assign q.out_opsize = head_opsize;
  assign q.out_last   = last_mem[rp];
  assign q.out_xpage1 = end1[12];
  assign q.out_xpage2 = end2[12];
endmodule

// File: tb/tb_rrag_mem_addr_queue.sv
// tb/tb_rrag_mem_addr_queue.sv - scoreboard bench for rrag_mem_addr_queue
module tb_rrag_mem_addr_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic clr;
  logic flush;
  always #5 clk = ~clk;

  rrag_mem_addr_queue_if #(.PTR_W(PTR_W)) q ();

  rrag_mem_addr_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .q     (q)
  );

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [1:0]  os;
    logic        last;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // access touches bytes [a, a+size-1]; crossing means the last byte lands in the next page
  function automatic logic crosses(input logic [31:0] a, input logic [1:0] os);
    int unsigned nbytes;
    nbytes = (os == 2'b01) ? 2 : (os == 2'b10) ? 4 : 1;
    return ((a % 4096) + nbytes - 1) >= 4096;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(q.count), 32'(sb.size()));
      chk("full", 32'(q.full), 32'(sb.size() == DEPTH));
      chk("out_valid", 32'(q.out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("out_addr1", q.out_addr1, sb[0].a1);
        chk("out_addr2", q.out_addr2, sb[0].a2);
        chk("out_opsize", 32'(q.out_opsize), 32'(sb[0].os));
        chk("out_last", 32'(q.out_last), 32'(sb[0].last));
        chk("out_xpage1", 32'(q.out_xpage1), 32'(crosses(sb[0].a1, sb[0].os)));
        chk("out_xpage2", 32'(q.out_xpage2), 32'(crosses(sb[0].a2, sb[0].os)));
      end
    end
  end

  task automatic cycle(input logic v, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [1:0] os, input logic rc, input logic rdy,
                       input logic fl, input logic cl);
    bit   acc;
    bit   take;
    ent_t e;
    @(negedge clk);
    q.in_valid    = v;
    q.in_addr1    = a1;
    q.in_addr2    = a2;
    q.in_opsize   = os;
    q.in_rep_cont = rc;
    q.out_ready   = rdy;
    flush         = fl;
    clr           = cl;
    @(posedge clk);
    acc  = v && (sb.size() < DEPTH);
    take = rdy && (sb.size() != 0);
    if (cl || fl) begin
      sb.delete();
    end else begin
      if (take) void'(sb.pop_front());
      if (acc) begin
        e.a1 = a1; e.a2 = a2; e.os = os; e.last = ~rc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic push(input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] os,
                      input logic rc, input logic rdy);
    cycle(1'b1, a1, a2, os, rc, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 1) == 0) a[11:0] = 12'hFF8 + 12'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    q.in_valid = 1'b0; q.in_addr1 = '0; q.in_addr2 = '0; q.in_opsize = '0;
    q.in_rep_cont = 1'b0; q.out_ready = 1'b0; flush = 1'b0; clr = 1'b1;

    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    push(32'h1000, 32'h2000, 2'b10, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    for (int i = 1; i <= 5; i++) push(32'h100 * i, 32'h5000 + i, 2'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    for (int i = 0; i < 4; i++) push(32'h3000 + i, 32'h4000 + i, 2'b01, 1'b1, 1'b0);
    push(32'h3FFF, 32'h4FFF, 2'b01, 1'b0, 1'b1);
    push(32'h3FFF, 32'h4FFF, 2'b01, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    push(32'h0FFE, 32'h7000, 2'b01, 1'b1, 1'b0);
    push(32'h0FFF, 32'h7002, 2'b01, 1'b1, 1'b0);
    push(32'h1000, 32'h7004, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    for (int i = 0; i < 3; i++) push(32'h8000 + i, 32'h9FFD, 2'b10, 1'b1, 1'b0);
    cycle(1'b1, 32'hDEAD, 32'hBEEF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    push(32'hABC0, 32'hABC4, 2'b10, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    for (int i = 0; i < 10; i++) push(32'hC000 + 4 * i, 32'hCFFC + i, 2'(i), 1'(i & 1), 1'(i & 1));
    for (int i = 0; i < 3; i++) idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_addr(), rand_addr(), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
